read_arbiter: RTL and testbench
===============================

READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): PORT_NUM, 3, requesting read ports (conv, datasaver, misc).
REQ-002 SHALL have parameters: ROW_PARA, 4, bank enables; ADDR_WIDTH, 48; DATA_WIDTH, 256; MEM_LATENCY, 3, memory read latency.
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 Ports: clk, input, 1, clock; rst_n, input, 1, async active-low reset.
REQ-005 Ports: read_en_i, input, PORT_NUM, per-port request; read_bank_en_i, input, PORT_NUM*ROW_PARA; read_addr_i, input, PORT_NUM*ADDR_WIDTH.
REQ-006 Ports: read_addr_ready_o, output, PORT_NUM, per-port acceptance; read_nostall_i, input, PORT_NUM, port may take new data.
REQ-007 Ports: read_data_valid_o, output, PORT_NUM, one-hot return strobe; read_data_o, output, DATA_WIDTH, shared return data.
REQ-008 Ports: mem_rd_en_o, output, 1; mem_bank_en_o, output, ROW_PARA; mem_addr_o, output, ADDR_WIDTH; mem_rd_data_i, input, DATA_WIDTH.

Function
REQ-009 Port k eligible when read_en_i[k] and read_nostall_i[k] are both high.
REQ-010 read_addr_ready_o SHALL be combinational, at most one bit high per cycle, to the first eligible port at or after the registered round-robin pointer.
REQ-011 Acceptance = read_en_i[k] & read_addr_ready_o[k]; one acceptance per cycle, back-to-back acceptance every cycle allowed.
REQ-012 After acceptance of port k, pointer SHALL become (k+1) mod PORT_NUM; with no acceptance pointer SHALL hold.
REQ-013 No eligible port (including all nostall low) -> read_addr_ready_o all zero, mem_rd_en_o low next cycle.
REQ-014 Accepted bank_en/addr SHALL be registered onto mem_bank_en_o/mem_addr_o with mem_rd_en_o high exactly one cycle after acceptance; zero bank_en still issued.
REQ-015 mem_rd_data_i valid exactly MEM_LATENCY cycles after mem_rd_en_o; a valid/port-id tag shift register of depth MEM_LATENCY SHALL track each issue.
REQ-016 Return data SHALL be registered: read_data_valid_o[k] high for one cycle, MEM_LATENCY+2 cycles (5 default) after acceptance, read_data_o valid the same cycle.
REQ-017 read_data_o SHALL hold last returned value when no valid strobe.
REQ-018 Deasserting read_nostall_i[k] SHALL block new grants only; in-flight returns to port k SHALL still be delivered.
REQ-019 Returns SHALL preserve acceptance order; no data dropped or duplicated.

Reset
REQ-020 On rst_n low (asynchronous): all outputs zero, pointer = 0, tag pipeline cleared.
REQ-021 Reset mid-operation SHALL discard in-flight reads; memory data arriving after reset release SHALL produce no read_data_valid_o.
REQ-022 read_addr_ready_o SHALL be zero while rst_n low.

Configuration
REQ-023 Macro READ_ARBITER_PERF_CNT_EN defined: SHALL add outputs grant_cnt_o (PORT_NUM*32, per-port accepted requests) and stall_cnt_o (32, cycles with a request but no acceptance), saturating at all-ones, cleared by reset.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Shared package read_pool_pkg SHALL hold PORT_NUM, ROW_PARA, ADDR_WIDTH, DATA_WIDTH, MEM_LATENCY defaults, READ_CYCLE (= MEM_LATENCY+2) and the port-id typedef.
REQ-026 Grant logic and pointer SHALL be a sub-module rr_arbiter; tag pipeline and data return stay in read_arbiter.

Verification
REQ-027 Single request port 1, addr 0x100, bank 4'b0011 -> ready[1] same cycle; mem_rd_en_o, addr 0x100 next cycle; read_data_valid_o = 3'b010 five cycles after acceptance with data echoed.
REQ-028 All three ports request continuously, nostall high -> grants 0,1,2,0,1,2 one per cycle; returns in same order, each exactly 5 cycles later.
REQ-029 Ports 0 and 2 request, nostall[0] low -> only port 2 granted; in-flight port-0 reads still return.
REQ-030 Assert rst_n low two cycles after three back-to-back acceptances -> all outputs zero immediately; no read_data_valid_o after release; pointer restarts at port 0.
REQ-031 With READ_ARBITER_PERF_CNT_EN: 10 grants to port 0, 4 cycles all-nostall-low with requests -> grant_cnt port 0 = 10, stall_cnt = 4; without macro the build has no counter ports.

Source files
------------

// File: rtl/read_pool_pkg.sv
// rtl/read_pool_pkg.sv - shared defaults and types for the read pool arbiter
package read_pool_pkg;

  localparam int PORT_NUM    = 3;
  localparam int ROW_PARA    = 4;
  localparam int ADDR_WIDTH  = 48;
  localparam int DATA_WIDTH  = 256;
  localparam int MEM_LATENCY = 3;
  // Acceptance to return strobe: one cycle to issue, MEM_LATENCY in memory, one to register.
  localparam int READ_CYCLE  = MEM_LATENCY + 2;

  localparam int PORT_ID_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  typedef logic [PORT_ID_W-1:0] port_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with registered pointer
module rr_arbiter
  import read_pool_pkg::*;
#(
  parameter int PORT_NUM = read_pool_pkg::PORT_NUM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORT_NUM-1:0] req,
  output logic [PORT_NUM-1:0] grant
);

  localparam int ID_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] idx_v;
  logic            found;
  int              idx;

  // Scan from the pointer for the first requester; the pointer moves just past the winner.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_v = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= PORT_NUM) begin
        idx = idx - PORT_NUM;
      end
      idx_v = ID_W'(idx);
      if (!found && req[idx_v]) begin
        found        = 1'b1;
        grant[idx_v] = 1'b1;
        if (idx == PORT_NUM - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = ID_W'(idx + 1);
        end
      end
    end
    // No grants may leak out combinationally while the block is held in reset.
    if (!rst_n) begin
      grant = '0;
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/read_arbiter.sv
// rtl/read_arbiter.sv - multi-port read arbiter with tagged in-order return (optional READ_ARBITER_PERF_CNT_EN counters)
module read_arbiter
  import read_pool_pkg::*;
#(
  parameter int PORT_NUM    = read_pool_pkg::PORT_NUM,
  parameter int ROW_PARA    = read_pool_pkg::ROW_PARA,
  parameter int ADDR_WIDTH  = read_pool_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = read_pool_pkg::DATA_WIDTH,
  parameter int MEM_LATENCY = read_pool_pkg::MEM_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUM-1:0]            read_en_i,
  input  logic [PORT_NUM*ROW_PARA-1:0]   read_bank_en_i,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] read_addr_i,
  output logic [PORT_NUM-1:0]            read_addr_ready_o,
  input  logic [PORT_NUM-1:0]            read_nostall_i,
  output logic [PORT_NUM-1:0]            read_data_valid_o,
  output logic [DATA_WIDTH-1:0]          read_data_o,
  output logic                           mem_rd_en_o,
  output logic [ROW_PARA-1:0]            mem_bank_en_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic [DATA_WIDTH-1:0]          mem_rd_data_i
`ifdef READ_ARBITER_PERF_CNT_EN
  ,
  output logic [PORT_NUM*32-1:0]         grant_cnt_o,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int ID_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0]   eligible;
  logic [PORT_NUM-1:0]   grant;
  logic [PORT_NUM-1:0]   accept;
  logic                  any_accept;
  logic [ID_W-1:0]       sel_id;
  logic [ROW_PARA-1:0]   sel_bank;
  logic [ADDR_WIDTH-1:0] sel_addr;

  logic [ID_W-1:0]        issue_id_q;
  logic [MEM_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]        tag_id [MEM_LATENCY];

  // A port stalled downstream is not offered a grant, but its in-flight reads still return.
  assign eligible          = read_en_i & read_nostall_i;
  assign read_addr_ready_o = grant;
  assign accept            = read_en_i & grant;

  rr_arbiter #(
    .PORT_NUM (PORT_NUM)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (eligible),
    .grant (grant)
  );

  // Mux the accepted port's request fields; grant is one-hot so at most one port matches.
  always_comb begin
    any_accept = 1'b0;
    sel_id     = '0;
    sel_bank   = '0;
    sel_addr   = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (accept[k]) begin
        any_accept = 1'b1;
        sel_id     = ID_W'(k);
        sel_bank   = read_bank_en_i[k*ROW_PARA +: ROW_PARA];
        sel_addr   = read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Issue stage: register the accepted request onto the memory port (zero bank enable still issues).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en_o   <= 1'b0;
      mem_bank_en_o <= '0;
      mem_addr_o    <= '0;
      issue_id_q    <= '0;
    end else begin
      mem_rd_en_o <= any_accept;
      if (any_accept) begin
        mem_bank_en_o <= sel_bank;
        mem_addr_o    <= sel_addr;
        issue_id_q    <= sel_id;
      end
    end
  end

  // Tag pipeline mirrors the memory latency so the last stage lines up with valid read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= mem_rd_en_o;
      tag_id[0] <= issue_id_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Return stage: one-hot strobe to the owning port; data holds its last value between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_valid_o <= '0;
      read_data_o       <= '0;
    end else begin
      if (tag_v[MEM_LATENCY-1]) begin
        read_data_valid_o <= PORT_NUM'(1) << tag_id[MEM_LATENCY-1];
        read_data_o       <= mem_rd_data_i;
      end else begin
        read_data_valid_o <= '0;
      end
    end
  end

`ifdef READ_ARBITER_PERF_CNT_EN
  // Saturating per-port grant counts and a count of cycles where someone asked but nobody was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int k = 0; k < PORT_NUM; k++) begin
        if (accept[k] && (grant_cnt_o[k*32 +: 32] != 32'hFFFF_FFFF)) begin
          grant_cnt_o[k*32 +: 32] <= grant_cnt_o[k*32 +: 32] + 32'd1;
        end
      end
      if ((|read_en_i) && !any_accept && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_read_arbiter.sv
// tb/tb_read_arbiter.sv - randomized self-checking bench for read_arbiter against a transaction-level model
module tb_read_arbiter;
  import read_pool_pkg::*;

  localparam int P    = 3;
  localparam int R    = 4;
  localparam int AW   = 48;
  localparam int DW   = 256;
  localparam int LAST = 1200;

  logic            clk;
  logic            rst_n;
  logic [P-1:0]    read_en_i;
  logic [P*R-1:0]  read_bank_en_i;
  logic [P*AW-1:0] read_addr_i;
  logic [P-1:0]    read_addr_ready_o;
  logic [P-1:0]    read_nostall_i;
  logic [P-1:0]    read_data_valid_o;
  logic [DW-1:0]   read_data_o;
  logic            mem_rd_en_o;
  logic [R-1:0]    mem_bank_en_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_rd_data_i;
`ifdef READ_ARBITER_PERF_CNT_EN
  logic [P*32-1:0] grant_cnt_o;
  logic [31:0]     stall_cnt_o;
`endif

  read_arbiter #(
    .PORT_NUM    (P),
    .ROW_PARA    (R),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .read_en_i         (read_en_i),
    .read_bank_en_i    (read_bank_en_i),
    .read_addr_i       (read_addr_i),
    .read_addr_ready_o (read_addr_ready_o),
    .read_nostall_i    (read_nostall_i),
    .read_data_valid_o (read_data_valid_o),
    .read_data_o       (read_data_o),
    .mem_rd_en_o       (mem_rd_en_o),
    .mem_bank_en_o     (mem_bank_en_o),
    .mem_addr_o        (mem_addr_o),
    .mem_rd_data_i     (mem_rd_data_i)
`ifdef READ_ARBITER_PERF_CNT_EN
    ,
    .grant_cnt_o       (grant_cnt_o),
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory content is a fixed function of the address so returns can be predicted end to end.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], a, ~a, a + 48'd1, a ^ 48'h5A5A_C3C3_0F0F, {a[23:0], a[47:24]}};
  endfunction

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    int            due;
  } ret_t;

  ret_t          ret_q[$];
  logic          hist_v [4];
  logic [AW-1:0] hist_a [4];
  int            ptr_m;
  logic          exp_iss_v;
  logic [R-1:0]  exp_bank;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] last_data;
  int            grant_m [P];
  int            stall_m;

  task automatic drive(input int n);
    logic [63:0] r64;
    logic [P-1:0] en;
    logic [P-1:0] ns;
    en = '0;
    ns = '1;
    for (int k = 0; k < P; k++) begin
      r64 = {$urandom(), $urandom()};
      read_addr_i[k*AW +: AW] = r64[AW-1:0];
      read_bank_en_i[k*R +: R] = R'($urandom_range(0, 15));
    end
    if (n == 3) begin
      en = 3'b010;
      read_addr_i[1*AW +: AW] = 48'h100;
      read_bank_en_i[1*R +: R] = 4'b0011;
    end else if (n >= 11 && n <= 22) begin
      en = 3'b111;
    end else if (n >= 23 && n <= 35) begin
      en = 3'b101;
      if (n >= 24) ns = 3'b110;
    end else if ((n >= 41 && n <= 43) || (n >= 48 && n <= 52)) begin
      en = 3'b111;
    end else if (n >= 54 && n <= 57) begin
      en = 3'b111;
      ns = 3'b000;
    end else if (n >= 60 && n < LAST) begin
      en = P'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ns = P'($urandom_range(0, 7));
    end
    read_en_i      = en;
    read_nostall_i = ns;
  endtask

  task automatic check_outputs(input int n);
    logic [P-1:0] oh;
    logic [DW-1:0] exp_d;
    logic [63:0] g0;
    logic [63:0] g1;
    for (int i = 3; i > 0; i--) begin
      hist_v[i] = hist_v[i-1];
      hist_a[i] = hist_a[i-1];
    end
    hist_v[0] = mem_rd_en_o;
    hist_a[0] = mem_addr_o;
    g0 = {$urandom(), $urandom()};
    g1 = {$urandom(), $urandom()};
    mem_rd_data_i = hist_v[3] ? mem_word(hist_a[3]) : {g0, g1, ~g0, g1 ^ g0};

    check("mem_rd_en", DW'(mem_rd_en_o), DW'(exp_iss_v));
    if (exp_iss_v) begin
      check("mem_bank_en", DW'(mem_bank_en_o), DW'(exp_bank));
      check("mem_addr", DW'(mem_addr_o), DW'(exp_addr));
    end
    oh    = '0;
    exp_d = last_data;
    if (ret_q.size() > 0 && ret_q[0].due == n) begin
      oh[ret_q[0].port] = 1'b1;
      exp_d     = mem_word(ret_q[0].addr);
      last_data = exp_d;
      void'(ret_q.pop_front());
    end
    check("data_valid", DW'(read_data_valid_o), DW'(oh));
    check("read_data", read_data_o, exp_d);
  endtask

  task automatic model_step(input int n);
    logic [P-1:0] elig;
    logic [P-1:0] exp_ready;
    int acc;
    int k;
    ret_t r;
    elig      = read_en_i & read_nostall_i;
    exp_ready = '0;
    acc       = -1;
    for (int i = 0; i < P; i++) begin
      k = (ptr_m + i) % P;
      if (acc < 0 && elig[k]) acc = k;
    end
    if (acc >= 0) exp_ready[acc] = 1'b1;
    check("addr_ready", DW'(read_addr_ready_o), DW'(exp_ready));
    exp_iss_v = (acc >= 0);
    if (acc >= 0) begin
      exp_bank = read_bank_en_i[acc*R +: R];
      exp_addr = read_addr_i[acc*AW +: AW];
      r.port = acc;
      r.addr = exp_addr;
      r.due  = n + READ_CYCLE;
      ret_q.push_back(r);
      ptr_m = (acc + 1) % P;
      grant_m[acc]++;
    end else if (|read_en_i) begin
      stall_m++;
    end
  endtask

  task automatic reset_checks();
    check("rst_ready", DW'(read_addr_ready_o), '0);
    check("rst_rd_en", DW'(mem_rd_en_o), '0);
    check("rst_bank", DW'(mem_bank_en_o), '0);
    check("rst_addr", DW'(mem_addr_o), '0);
    check("rst_valid", DW'(read_data_valid_o), '0);
    check("rst_data", read_data_o, '0);
    ret_q.delete();
    exp_iss_v = 1'b0;
    last_data = '0;
    ptr_m     = 0;
    for (int i = 0; i < P; i++) grant_m[i] = 0;
    stall_m   = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    read_en_i      = '1;
    read_nostall_i = '1;
    read_bank_en_i = '1;
    read_addr_i    = '1;
    mem_rd_data_i  = '0;
    for (int i = 0; i < 4; i++) begin
      hist_v[i] = 1'b0;
      hist_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    read_en_i = '0;
    rst_n     = 1'b1;

    for (int n = 0; n < LAST + 12; n++) begin
      @(posedge clk);
      #1;
      check_outputs(n);
      drive(n);
      if (n == 45) rst_n = 1'b0;
      if (n == 46) rst_n = 1'b1;
      #1;
      if (!rst_n) begin
        reset_checks();
      end else begin
        model_step(n);
      end
    end
    @(posedge clk);
    #1;
    check("drain_empty", DW'(ret_q.size()), '0);
`ifdef READ_ARBITER_PERF_CNT_EN
    for (int k = 0; k < P; k++) begin
      check("grant_cnt", DW'(grant_cnt_o[k*32 +: 32]), DW'(grant_m[k]));
    end
    check("stall_cnt", DW'(stall_cnt_o), DW'(stall_m));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
